// File: rtl/fpu_addsub_p.sv
// fpu_addsub_p: floating-point add/subtract for a {sign, exp, mant} word (hidden 1, no denormals).
// Latency: start is taken in IDLE; done pulses for one cycle after the 5th following edge.
// Backpressure: none. start is ignored while busy, so issue the next operation at or after done.
// Ports: clock100KHz, reset (async, active-high); op_A_in/op_B_in/op_sub/round_mode/start request;
//        busy and done handshake; data_out and status_out (one-hot EXACT/INEXACT/OVERFLOW/UNDERFLOW)
//        hold the last result until the next done.
module fpu_addsub_p #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25
) (
  input  logic                 clock100KHz,
  input  logic                 reset,
  input  logic [EXP_W+MAN_W:0] op_A_in,
  input  logic [EXP_W+MAN_W:0] op_B_in,
  input  logic                 op_sub,
  input  logic                 round_mode,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] data_out,
  output logic [3:0]           status_out
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;        // significand including the hidden bit
  localparam int EXT_W  = SIG_W + 3;        // significand plus guard, round, sticky
  localparam int SUM_W  = EXT_W + 1;        // one carry bit above the extended significand
  localparam int WIDE_W = 2 * SIG_W + 4;    // {sig, G, R} plus room for every bit a shift can push out
  localparam int E_W    = EXP_W + 2;        // signed working exponent: room for carries and underflow
  localparam int LZ_W   = $clog2(EXT_W + 1);
  localparam logic signed [E_W-1:0] EXP_OVF = E_W'((1 << EXP_W) - 1);

  localparam logic [3:0] ST_EXACT   = 4'b0001;
  localparam logic [3:0] ST_INEXACT = 4'b0010;
  localparam logic [3:0] ST_OVERFLOW = 4'b0100;
  localparam logic [3:0] ST_UNDERFLOW = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t                  state;
  logic [W-1:0]            a_q, b_q;          // b_q carries the effective (op_sub adjusted) sign
  logic                    rmode_q;
  logic [EXT_W-1:0]        big_q, small_q;
  logic                    eff_sub_q, sign_q;
  logic signed [E_W-1:0]   exp_q;
  logic [SUM_W-1:0]        sum_q;
  logic [EXT_W-1:0]        norm_q;
  logic                    zero_q;
  logic [W-1:0]            res_q;
  logic [3:0]              res_st_q;

  // ALIGN: order the operands by magnitude so ADD only ever subtracts smaller from larger,
  // then shift the smaller one right, ORing everything below the round bit into sticky.
  logic [EXP_W-1:0] a_exp, b_exp, big_exp, small_exp, exp_diff;
  logic [SIG_W-1:0] a_sig, b_sig, big_sig, small_sig;
  logic             a_big, big_sign, small_sign;
  logic [WIDE_W-1:0] wide;
  logic [EXT_W-1:0] small_ext;

  always_comb begin
    a_exp = a_q[W-2:MAN_W];
    b_exp = b_q[W-2:MAN_W];
    // A zero exponent field means zero; a zero significand falls straight through the datapath.
    a_sig = (a_exp == '0) ? '0 : {1'b1, a_q[MAN_W-1:0]};
    b_sig = (b_exp == '0) ? '0 : {1'b1, b_q[MAN_W-1:0]};
    a_big      = {a_exp, a_sig} >= {b_exp, b_sig};
    big_exp    = a_big ? a_exp : b_exp;
    small_exp  = a_big ? b_exp : a_exp;
    big_sig    = a_big ? a_sig : b_sig;
    small_sig  = a_big ? b_sig : a_sig;
    big_sign   = a_big ? a_q[W-1] : b_q[W-1];
    small_sign = a_big ? b_q[W-1] : a_q[W-1];
    exp_diff   = big_exp - small_exp;
    wide       = {small_sig, {(WIDE_W-SIG_W){1'b0}}} >> exp_diff;
    if (32'(exp_diff) >= 32'(MAN_W + 3)) begin
      small_ext = {{(EXT_W-1){1'b0}}, |small_sig};
    end else begin
      small_ext = {wide[WIDE_W-1 -: EXT_W-1], |wide[WIDE_W-EXT_W:0]};
    end
  end

  // ADD
  logic [SUM_W-1:0] sum_d;

  always_comb begin
    if (eff_sub_q) begin
      sum_d = {1'b0, big_q} - {1'b0, small_q};
    end else begin
      sum_d = {1'b0, big_q} + {1'b0, small_q};
    end
  end

  // NORM: carry-out shifts right once, otherwise shift left by the leading-zero count.
  logic [LZ_W-1:0]       lz;
  logic [EXT_W-1:0]      norm_d;
  logic signed [E_W-1:0] norm_exp_d;

  always_comb begin
    lz = LZ_W'(EXT_W);
    for (int i = 0; i < EXT_W; i++) begin
      if (sum_q[i]) lz = LZ_W'(EXT_W - 1 - i);
    end
    if (sum_q[SUM_W-1]) begin
      norm_d     = {sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
      norm_exp_d = exp_q + E_W'(1);
    end else begin
      norm_d     = sum_q[EXT_W-1:0] << lz;
      norm_exp_d = exp_q - E_W'(lz);
    end
  end

  // ROUND and pack, including range checks on the final exponent.
  logic [SIG_W-1:0]      keep;
  logic                  g_bit, r_bit, s_bit, inc;
  logic [SIG_W:0]        rounded;
  logic [MAN_W-1:0]      mant_f;
  logic signed [E_W-1:0] exp_f;
  logic [W-1:0]          res_d;
  logic [3:0]            res_st_d;

  always_comb begin
    keep    = norm_q[EXT_W-1:3];
    g_bit   = norm_q[2];
    r_bit   = norm_q[1];
    s_bit   = norm_q[0];
    inc     = ~rmode_q & g_bit & (r_bit | s_bit | keep[0]);
    rounded = {1'b0, keep} + {{SIG_W{1'b0}}, inc};
    exp_f   = exp_q;
    mant_f  = rounded[MAN_W-1:0];
    if (rounded[SIG_W]) begin
      exp_f  = exp_q + E_W'(1);
      mant_f = rounded[MAN_W:1];
    end
    if (zero_q) begin
      res_d    = '0;
      res_st_d = ST_EXACT;
    end else if (exp_f >= EXP_OVF) begin
      res_d    = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_st_d = ST_OVERFLOW;
    end else if (exp_f[E_W-1] || (exp_f == '0)) begin
      res_d    = {sign_q, {(W-1){1'b0}}};
      res_st_d = ST_UNDERFLOW;
    end else begin
      res_d    = {sign_q, exp_f[EXP_W-1:0], mant_f};
      res_st_d = (g_bit | r_bit | s_bit) ? ST_INEXACT : ST_EXACT;
    end
  end

  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_out   <= '0;
      status_out <= ST_EXACT;
      a_q        <= '0;
      b_q        <= '0;
      rmode_q    <= 1'b0;
      big_q      <= '0;
      small_q    <= '0;
      eff_sub_q  <= 1'b0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      sum_q      <= '0;
      norm_q     <= '0;
      zero_q     <= 1'b0;
      res_q      <= '0;
      res_st_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q     <= op_A_in;
            b_q     <= {op_B_in[W-1] ^ op_sub, op_B_in[W-2:0]};
            rmode_q <= round_mode;
            busy    <= 1'b1;
            state   <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          big_q     <= {big_sig, 3'b000};
          small_q   <= small_ext;
          eff_sub_q <= big_sign ^ small_sign;
          sign_q    <= big_sign;
          exp_q     <= E_W'(big_exp);
          state     <= S_ADD;
        end
        S_ADD: begin
          sum_q <= sum_d;
          state <= S_NORM;
        end
        S_NORM: begin
          norm_q <= norm_d;
          exp_q  <= norm_exp_d;
          zero_q <= (sum_q == '0);
          state  <= S_ROUND;
        end
        S_ROUND: begin
          res_q    <= res_d;
          res_st_q <= res_st_d;
          state    <= S_DONE;
        end
        S_DONE: begin
          data_out   <= res_q;
          status_out <= res_st_q;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub_p.sv
// tb_fpu_addsub_p: randomized and directed checks of fpu_addsub_p against an exact-arithmetic model.
// Latency: each operation is expected to raise done exactly 5 edges after start is taken.
// Backpressure: the bench waits for done before issuing the next operation.
module tb_fpu_addsub_p;

  localparam int EXP_W = 6;
  localparam int MAN_W = 25;
  localparam int W     = 32;

  logic         clock100KHz = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] op_A_in = '0;
  logic [W-1:0] op_B_in = '0;
  logic         op_sub = 1'b0;
  logic         round_mode = 1'b0;
  logic         start = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] data_out;
  logic [3:0]   status_out;

  int checks = 0;
  int errors = 0;

  fpu_addsub_p #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clock100KHz(clock100KHz),
    .reset(reset),
    .op_A_in(op_A_in),
    .op_B_in(op_B_in),
    .op_sub(op_sub),
    .round_mode(round_mode),
    .start(start),
    .busy(busy),
    .done(done),
    .data_out(data_out),
    .status_out(status_out)
  );

  always #5 clock100KHz = ~clock100KHz;

  // Exact model: scale both operands to a common integer, add/subtract exactly, then round.
  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sub, input logic rm,
                                    output logic [W-1:0] res, output logic [3:0] st);
    int ea, eb, emin, p, e, sh;
    logic sa, sb, sr, inexact;
    logic [127:0] va, vb, m, q, rem, half;
    ea = int'(a[30:25]);
    eb = int'(b[30:25]);
    sa = a[31];
    sb = b[31] ^ sub;
    va = (ea == 0) ? 128'd0 : {102'd0, 1'b1, a[24:0]};
    vb = (eb == 0) ? 128'd0 : {102'd0, 1'b1, b[24:0]};
    if (va == 0 && vb == 0) begin
      res = '0; st = 4'b0001; return;
    end
    if (va == 0) emin = eb;
    else if (vb == 0) emin = ea;
    else emin = (ea < eb) ? ea : eb;
    if (va != 0) va = va << (ea - emin);
    if (vb != 0) vb = vb << (eb - emin);
    m = 0; sr = 1'b0;
    if (sa == sb) begin m = va + vb; sr = sa; end
    else if (va > vb) begin m = va - vb; sr = sa; end
    else if (vb > va) begin m = vb - va; sr = sb; end
    if (m == 0) begin
      res = '0; st = 4'b0001; return;
    end
    p = 0;
    for (int i = 0; i < 128; i++) if (m[i]) p = i;
    e = emin - MAN_W + p;
    inexact = 1'b0;
    if (p > MAN_W) begin
      sh = p - MAN_W;
      q = m >> sh;
      rem = m - (q << sh);
      half = 128'd1 << (sh - 1);
      inexact = (rem != 0);
      if (!rm && (rem > half || (rem == half && q[0]))) q = q + 1;
    end else begin
      q = m << (MAN_W - p);
    end
    if (q[MAN_W+1]) begin q = q >> 1; e = e + 1; end
    if (e >= 63) begin
      res = {sr, 6'h3f, 25'd0}; st = 4'b0100;
    end else if (e <= 0) begin
      res = {sr, 31'd0}; st = 4'b1000;
    end else begin
      res = {sr, 6'(e), q[24:0]}; st = inexact ? 4'b0010 : 4'b0001;
    end
  endfunction

  // Issues one operation starting at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic rm, output logic [W-1:0] res, output logic [3:0] st,
                        output int lat);
    op_A_in = a; op_B_in = b; op_sub = sub; round_mode = rm; start = 1'b1;
    @(posedge clock100KHz);
    @(negedge clock100KHz);
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock100KHz);
      @(negedge clock100KHz);
      if (done) begin lat = n; break; end
    end
    res = data_out;
    st = status_out;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock100KHz);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", data_out); end
    checks++; if (status_out !== 4'b0001) begin errors++; $display("FAIL reset_status: got %b expected 0001", status_out); end
    reset = 1'b0;
    repeat (2) @(negedge clock100KHz);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_directed();
    logic [W-1:0] da [9], db [9], dr [9];
    logic         ds [9], dm [9];
    logic [3:0]   dst [9];
    logic [W-1:0] res;
    logic [3:0]   st;
    int           lat;
    da  = '{32'h3E000000, 32'h3E000000, 32'h7DFFFFFF, 32'h03000000, 32'h3E000000,
            32'h3E000001, 32'h00000000, 32'hBE000000, 32'h3E000000};
    db  = '{32'h3E000000, 32'h3E000000, 32'h7DFFFFFF, 32'h02000000, 32'h0A000000,
            32'h0A000000, 32'h3E000000, 32'h00000000, 32'h1F000000};
    ds  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    dm  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    dr  = '{32'h40000000, 32'h00000000, 32'h7E000000, 32'h00000000, 32'h3E000000,
            32'h3E000002, 32'hBE000000, 32'hBE000000, 32'h3E000300};
    dst = '{4'b0001, 4'b0001, 4'b0100, 4'b1000, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0001};
    for (int i = 0; i < 9; i++) begin
      run_op(da[i], db[i], ds[i], dm[i], res, st, lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 5", i, lat); end
      checks++; if (res !== dr[i]) begin errors++; $display("FAIL dir%0d_data: got %h expected %h", i, res, dr[i]); end
      checks++; if (st !== dst[i]) begin errors++; $display("FAIL dir%0d_status: got %b expected %b", i, st, dst[i]); end
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    int extra_done;
    op_A_in = 32'h3E000000; op_B_in = 32'h0A000000; op_sub = 1'b0; round_mode = 1'b0; start = 1'b1;
    @(posedge clock100KHz);
    @(negedge clock100KHz);
    op_A_in = 32'h7DFFFFFF; op_B_in = 32'h7DFFFFFF; op_sub = 1'b0; round_mode = 1'b1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy_high: got %b expected 1", busy); end
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock100KHz);
      @(negedge clock100KHz);
      if (n == 3) start = 1'b0;
      if (done) begin lat = n; break; end
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL ignore_latency: got %0d expected 5", lat); end
    checks++; if (data_out !== 32'h3E000000) begin errors++; $display("FAIL ignore_data: got %h expected 3E000000", data_out); end
    checks++; if (status_out !== 4'b0010) begin errors++; $display("FAIL ignore_status: got %b expected 0010", status_out); end
    extra_done = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clock100KHz);
      if (done || busy) extra_done++;
    end
    checks++; if (extra_done !== 0) begin errors++; $display("FAIL ignore_no_second_op: got %0d active cycles expected 0", extra_done); end
  endtask

  task automatic gen_operand(input int e_ref, output logic [W-1:0] opnd, output int e_out);
    int mode, e;
    logic [31:0] m;
    mode = $urandom_range(0, 9);
    if (mode < 5) e = e_ref + int'($urandom_range(0, 6)) - 3;
    else if (mode < 7) e = e_ref - int'($urandom_range(24, 30));
    else if (mode < 8) e = 0;
    else e = int'($urandom_range(1, 62));
    if (e < 0) e = 0;
    if (e > 62) e = 62;
    m = $urandom;
    if ($urandom_range(0, 7) == 0) m = 32'h0;
    if ($urandom_range(0, 7) == 0) m = 32'hFFFFFFFF;
    opnd = {1'($urandom), 6'(e), m[24:0]};
    e_out = e;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, tmp, res, exp_res;
    logic [3:0]   st, exp_st;
    logic         sub, rm;
    int           ea, eb, lat;
    logic [31:0]  m;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0)
        ea = ($urandom_range(0, 1) == 1) ? int'($urandom_range(60, 62)) : int'($urandom_range(1, 3));
      else
        ea = int'($urandom_range(1, 62));
      m = $urandom;
      a = {1'($urandom), 6'(ea), m[24:0]};
      gen_operand(ea, b, eb);
      if ($urandom_range(0, 1) == 1) begin tmp = a; a = b; b = tmp; end
      sub = 1'($urandom);
      rm  = 1'($urandom);
      ref_model(a, b, sub, rm, exp_res, exp_st);
      run_op(a, b, sub, rm, res, st, lat);
      checks++; if (res !== exp_res || st !== exp_st || lat !== 5) begin
        errors++;
        $display("FAIL rand%0d: a=%h b=%h sub=%b rm=%b got %h/%b lat %0d expected %h/%b lat 5",
                 k, a, b, sub, rm, res, st, lat, exp_res, exp_st);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, res, exp_res;
    logic [3:0]   st, exp_st;
    int           lat, eb;
    for (int k = 0; k < 6; k++) begin
      gen_operand(31, a, eb);
      gen_operand(31, b, eb);
      ref_model(a, b, 1'(k), 1'b0, exp_res, exp_st);
      run_op(a, b, 1'(k), 1'b0, res, st, lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL b2b%0d_latency: got %0d expected 5", k, lat); end
      checks++; if (res !== exp_res || st !== exp_st) begin
        errors++; $display("FAIL b2b%0d_result: got %h/%b expected %h/%b", k, res, st, exp_res, exp_st);
      end
    end
    @(negedge clock100KHz);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse_width: got %b expected 0", done); end
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] res;
    logic [3:0]   st;
    int           lat, stray;
    run_op(32'h3E000000, 32'h3E000000, 1'b0, 1'b0, res, st, lat);
    op_A_in = 32'h7DFFFFFF; op_B_in = 32'h3E000000; op_sub = 1'b0; round_mode = 1'b0; start = 1'b1;
    @(posedge clock100KHz);
    @(negedge clock100KHz);
    start = 1'b0;
    repeat (2) begin @(posedge clock100KHz); @(negedge clock100KHz); end
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", done); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL midreset_data: got %h expected 00000000", data_out); end
    checks++; if (status_out !== 4'b0001) begin errors++; $display("FAIL midreset_status: got %b expected 0001", status_out); end
    @(negedge clock100KHz);
    reset = 1'b0;
    stray = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clock100KHz);
      if (done || busy) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", stray); end
    run_op(32'h3E000000, 32'h3E000000, 1'b0, 1'b0, res, st, lat);
    checks++; if (lat !== 5 || res !== 32'h40000000 || st !== 4'b0001) begin
      errors++; $display("FAIL midreset_recover: got %h/%b lat %0d expected 40000000/0001 lat 5", res, st, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_busy();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
